// File: rtl/sensor_scan_reporter_pkg.sv
// Shared definitions for the sensor scan/report datapath: FSM state codes,
// ASCII constants and the BCD-to-ASCII mapping.
package sensor_scan_reporter_pkg;

    typedef enum logic [3:0] {
        INATIVO     = 4'd0,
        MEDE        = 4'd1,
        ESPERA      = 4'd2,
        CAPTURA     = 4'd3,
        ENVIA       = 4'd4,
        AGUARDA_TX  = 4'd5,
        PROXIMO     = 4'd6,
        TERMINA     = 4'd7,
        AGUARDA_FIM = 4'd8,
        ESPERA_PER  = 4'd9
    } estado_t;

    localparam logic [2:0] ASCII_DIGIT_PREFIX = 3'b011;
    localparam logic [6:0] ASCII_ERRO         = 7'h3F;
    localparam logic [6:0] SEP_PADRAO         = 7'h23;
    localparam logic [6:0] TERM_PADRAO        = 7'h0A;

    function automatic logic [6:0] bcd_para_ascii(input logic [3:0] digito,
                                                  input logic       erro);
        if (erro || (digito > 4'd9))
            return ASCII_ERRO;
        return {ASCII_DIGIT_PREFIX, digito};
    endfunction

endpackage

// File: rtl/sensor_scan_reporter_if.sv
// Character-level handshake between the reporter and the serial transmitter.
interface sensor_scan_reporter_if;
    logic       tx_partida;
    logic [6:0] tx_dados;
    logic       tx_pronto;

    modport master (output tx_partida, output tx_dados, input tx_pronto);
    modport slave  (input tx_partida, input tx_dados, output tx_pronto);
endinterface

// File: rtl/bcd_ascii_sel.sv
// Picks the character to send from the captured measurements: a digit, '?'
// for an invalid digit or a timed-out channel, or the separator.
module bcd_ascii_sel
    import sensor_scan_reporter_pkg::*;
#(
    parameter int unsigned N_CH   = 3,
    parameter int unsigned DIGITS = 3,
    parameter logic [6:0]  SEP    = SEP_PADRAO,
    localparam int unsigned CW    = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned IW    = $clog2(DIGITS + 1)
) (
    input  logic [N_CH*4*DIGITS-1:0] shadow,
    input  logic [CW-1:0]            canal,
    input  logic [IW-1:0]            indice,
    input  logic [N_CH-1:0]          erro,
    output logic [6:0]               caractere
);
    logic [3:0] nibble;
    logic       canal_erro;

    always_comb begin
        nibble     = '0;
        canal_erro = 1'b0;
        caractere  = SEP;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (c == 32'(canal)) begin
                canal_erro = erro[c];
                for (int unsigned d = 0; d < DIGITS; d++) begin
                    if (d == 32'(indice))
                        nibble = shadow[c*4*DIGITS + (DIGITS-1-d)*4 +: 4];
                end
            end
        end
        if (32'(indice) < DIGITS)
            caractere = bcd_para_ascii(nibble, canal_erro);
    end
endmodule

// File: rtl/contador_m.sv
// Saturating up-counter 0..M-1 with synchronous restart and terminal flag.
module contador_m #(
    parameter int unsigned M = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_s,
    input  logic conta,
    output logic fim
);
    localparam int unsigned N = (M > 1) ? $clog2(M) : 1;

    logic [N-1:0] q;

    // Restart together with conta loads 1, so the restart cycle itself counts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (zera_s)
            q <= conta ? N'(1) : '0;
        else if (conta && (q != N'(M - 1)))
            q <= q + N'(1);
    end

    assign fim = (q == N'(M - 1));
endmodule

// File: rtl/sensor_scan_reporter.sv
// Periodic multi-channel ultrasonic scan with timeout, reported as one ASCII
// frame per scan through the character transmitter handshake.
module sensor_scan_reporter
    import sensor_scan_reporter_pkg::*;
#(
    parameter int unsigned N_CH    = 3,
    parameter int unsigned DIGITS  = 3,
    parameter int unsigned PERIOD  = 50_000_000,
    parameter int unsigned TIMEOUT = 3_000_000,
    parameter logic [6:0]  SEP     = SEP_PADRAO,
    parameter bit          TERM_EN = 1'b1,
    parameter logic [6:0]  TERM    = TERM_PADRAO
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_CH*4*DIGITS-1:0] medida,
    input  logic [N_CH-1:0]          pronto_med,
    sensor_scan_reporter_if.master   tx,
    output logic                     medir,
    output logic                     ocupado,
    output logic [N_CH-1:0]          erro_timeout,
    output logic [3:0]               db_estado
);
    localparam int unsigned CW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IW      = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] IDX_SEP = IW'(DIGITS);
    localparam logic [CW-1:0] CH_ULT  = CW'(N_CH - 1);

    estado_t                  estado, estado_prox;
    logic [N_CH-1:0]          sticky;
    logic [N_CH*4*DIGITS-1:0] shadow;
    logic [CW-1:0]            canal;
    logic [IW-1:0]            indice;
    logic [6:0]               caractere;
    logic                     todos_prontos, ultimo;
    logic                     periodo_fim, tempo_fim;

    assign todos_prontos = &(sticky | pronto_med);
    assign ultimo        = (indice == IDX_SEP) && (canal == CH_ULT);

    contador_m #(.M(PERIOD)) u_periodo (
        .clock  (clock),
        .reset  (reset),
        .zera_s (estado == MEDE),
        .conta  (estado != INATIVO),
        .fim    (periodo_fim)
    );

    contador_m #(.M(TIMEOUT)) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .zera_s (estado == MEDE),
        .conta  ((estado == MEDE) || (estado == ESPERA)),
        .fim    (tempo_fim)
    );

    bcd_ascii_sel #(.N_CH(N_CH), .DIGITS(DIGITS), .SEP(SEP)) u_sel (
        .shadow    (shadow),
        .canal     (canal),
        .indice    (indice),
        .erro      (erro_timeout),
        .caractere (caractere)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            estado <= INATIVO;
        else
            estado <= estado_prox;
    end

    always_comb begin
        estado_prox   = estado;
        medir         = 1'b0;
        tx.tx_partida = 1'b0;
        tx.tx_dados   = '0;
        unique case (estado)
            INATIVO:     if (enable) estado_prox = MEDE;
            MEDE: begin
                medir       = 1'b1;
                estado_prox = ESPERA;
            end
            ESPERA:      if (todos_prontos || tempo_fim) estado_prox = CAPTURA;
            CAPTURA:     estado_prox = ENVIA;
            ENVIA: begin
                tx.tx_partida = 1'b1;
                tx.tx_dados   = caractere;
                estado_prox   = AGUARDA_TX;
            end
            AGUARDA_TX: begin
                tx.tx_dados = caractere;
                if (tx.tx_pronto) estado_prox = PROXIMO;
            end
            PROXIMO: begin
                if (!ultimo)      estado_prox = ENVIA;
                else if (TERM_EN) estado_prox = TERMINA;
                else              estado_prox = ESPERA_PER;
            end
            TERMINA: begin
                tx.tx_partida = 1'b1;
                tx.tx_dados   = TERM;
                estado_prox   = AGUARDA_FIM;
            end
            AGUARDA_FIM: begin
                tx.tx_dados = TERM;
                if (tx.tx_pronto) estado_prox = ESPERA_PER;
            end
            ESPERA_PER: begin
                if (!enable)          estado_prox = INATIVO;
                else if (periodo_fim) estado_prox = MEDE;
            end
            default:     estado_prox = INATIVO;
        endcase
    end

    assign ocupado   = (estado != INATIVO);
    assign db_estado = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sticky       <= '0;
            shadow       <= '0;
            erro_timeout <= '0;
            canal        <= '0;
            indice       <= '0;
        end else begin
            unique case (estado)
                MEDE:    sticky <= '0;
                ESPERA:  sticky <= sticky | pronto_med;
                CAPTURA: begin
                    shadow       <= medida;
                    erro_timeout <= ~(sticky | pronto_med);
                    canal        <= '0;
                    indice       <= '0;
                end
                PROXIMO: begin
                    if (indice == IDX_SEP) begin
                        indice <= '0;
                        if (canal != CH_ULT) canal <= canal + CW'(1);
                    end else begin
                        indice <= indice + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/sensor_scan_reporter.md
Name: sensor_scan_reporter

Overview:
Parametrised successor to the fixed 3-sensor/3-digit measurement-and-report datapath. It periodically fires a measurement on N_CH ultrasonic interfaces and collects their BCD results with a per-channel timeout. It then streams one ASCII frame through a character-level serial transmitter handshake.
Per channel the frame is DIGITS digits, most significant first, then a separator, with an optional terminator at the end. It contains its own sequencing FSM, so no external unit controller is needed.

Parameters:
N_CH, 3, number of sensor channels (1..8)
DIGITS, 3, BCD digits per measurement (1..4)
PERIOD, 50_000_000, clock cycles between successive medir pulses
TIMEOUT, 3_000_000, max cycles waiting for pronto_med after medir
SEP, 7'h23, separator character after each channel ('#')
TERM_EN, 1, 1 = append TERM after last channel
TERM, 7'h0A, frame terminator (LF)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  1 = run periodic scans; 0 = stop after current frame
medida  in  N_CH*4*DIGITS  packed BCD; channel k at [k*4*DIGITS +: 4*DIGITS], MS digit highest
pronto_med  in  N_CH  per-channel measurement done pulse
tx_pronto  in  1  1-cycle pulse from transmitter: character finished
medir  out  1  1-cycle measure request to all sensors
tx_partida  out  1  1-cycle start pulse to transmitter
tx_dados  out  7  ASCII character, valid while tx_partida=1 and held until tx_pronto
ocupado  out  1  1 in every state except INATIVO
erro_timeout  out  N_CH  per-channel timeout flag of last scan
db_estado  out  4  FSM state code

Behaviour:
- Reset (reset=0, async): FSM to INATIVO. All counters, the shadow register, the sticky done vector and every output go to 0.
- States and codes:
  - INATIVO 0: enable=1 -> MEDE.
  - MEDE 1: medir=1 for exactly one cycle; clear sticky done vector, timeout counter and period counter -> ESPERA.
  - ESPERA 2: OR pronto_med into sticky vector each cycle. All bits set -> CAPTURA. Timeout counter reaches TIMEOUT-1 -> CAPTURA.
  - CAPTURA 3: latch medida into shadow register; erro_timeout <= ~sticky (pronto_med in this cycle also counts); clear channel/char indices -> ENVIA.
  - ENVIA 4: tx_partida=1 one cycle with current char -> AGUARDA_TX.
  - AGUARDA_TX 5: hold tx_dados; wait tx_pronto -> PROXIMO.
  - PROXIMO 6: advance char index (0..DIGITS); at DIGITS wrap to 0 and advance channel. After last SEP of the last channel -> TERMINA if TERM_EN, else -> ESPERA_PER. Otherwise -> ENVIA.
  - TERMINA 7: tx_partida with TERM -> AGUARDA_FIM.
  - AGUARDA_FIM 8: tx_pronto -> ESPERA_PER.
  - ESPERA_PER 9: enable=0 -> INATIVO. Period counter >= PERIOD-1 -> MEDE.
- Period counter starts at 0 in MEDE and counts every cycle through ESPERA_PER, saturating at PERIOD-1. If a frame outlasts PERIOD, the next MEDE follows ESPERA_PER by one cycle.
- Character mapping for char index i < DIGITS: digit = shadow nibble (DIGITS-1-i). ASCII = {3'b011, digit} if digit <= 9. ASCII = 7'h3F ('?') if digit > 9 or the channel timed out. Index i = DIGITS gives SEP.
- Frame length = N_CH*(DIGITS+1)+TERM_EN characters. Channel 0 is sent first.
- medida changes after CAPTURA do not affect the frame in progress.
- tx_pronto outside AGUARDA_TX/AGUARDA_FIM is ignored. pronto_med outside ESPERA is ignored.
- enable falling mid-frame: the frame completes, then INATIVO.
- erro_timeout holds until the next CAPTURA.
- Counter widths are $clog2 of their limits; no wrap is possible.

Decomposition:
- Shared package holds:
  - the state encoding localparams (INATIVO..ESPERA_PER, 4 bits);
  - ASCII constants: ASCII_DIGIT_PREFIX=3'b011, ASCII_ERRO=7'h3F, default SEP and TERM.
- One sub-module, bcd_ascii_sel: combinational selection of the char from the shadow register, channel index, char index and timeout vector.
- Counters are reuse instances of contador_m with the zera_s/conta interface.

Test Plan:
- Defaults, channels 0/1/2 medida = 0x123/0x045/0x999, all pronto within 100 cycles -> one medir pulse; frame "123#045#999#\n" (13 chars); erro_timeout=000.
- Channel 1 never asserts pronto -> CAPTURA exactly TIMEOUT cycles after MEDE; frame "123#???#999#\n"; erro_timeout=010.
- Channel 0 nibble 0xA (medida=0x1A3) -> "1?3#" for channel 0; erro_timeout bit 0 stays 0.
- PERIOD=2000 with a transmitter model taking 10 cycles per char -> medir pulses exactly 2000 cycles apart. With 300 cycles per char, the next medir comes 1 cycle after ESPERA_PER is entered.
- N_CH=1, DIGITS=4, TERM_EN=0, medida=0x2024 -> frame "2024#" (5 chars), then ESPERA_PER.
- Reset low during AGUARDA_TX -> all outputs 0 and db_estado=0 immediately. After release with enable=1, the next frame starts fresh from channel 0, digit 0.
